// File: rtl/pattern_gen_multi_if.sv
// Handshake bundle for pattern_gen_multi: start/selector/mode inputs and serial outputs.
// master drives the request side, slave is the generator.
interface pattern_gen_multi_if #(
  parameter int SEL_W = 3
);
  logic             en;
  logic [SEL_W-1:0] sel;
  logic [1:0]       mode;
  logic             pattern;
  logic             valid;
  logic             done;
  logic             busy;

  modport master (
    output en, sel, mode,
    input  pattern, valid, done, busy
  );

  modport slave (
    input  en, sel, mode,
    output pattern, valid, done, busy
  );
endinterface

// File: rtl/pattern_gen_multi.sv
// Serial pattern generator: maps sel to a PAT_W-bit code word and shifts it out, first bit one cycle after en.
// Optional trailing even-parity bit when PATGEN_PARITY_EN is defined.
module pattern_gen_multi #(
  parameter int SEL_W = 3,
  parameter int PAT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  pattern_gen_multi_if.slave bus
);
`ifdef PATGEN_PARITY_EN
  localparam int FRAME_W = PAT_W + 1;
`else
  localparam int FRAME_W = PAT_W;
`endif
  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT_LOW} state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic               pattern_q, pattern_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [PAT_W-1:0]   code;
  logic [FRAME_W-1:0] frame_msb, frame_lsb;
  logic               load_bit, adv_bit;
  logic [FRAME_W-1:0] load_shift, adv_shift;

  // Upper bits replicate the selector MSB; the rest copy the selector low bits.
  always_comb begin
    code = {PAT_W{bus.sel[SEL_W-1]}};
    code[SEL_W-2:0] = bus.sel[SEL_W-2:0];
  end

`ifdef PATGEN_PARITY_EN
  // Parity sits on the side that is shifted out last for each bit order.
  assign frame_msb = {code, ^code};
  assign frame_lsb = {^code, code};
`else
  assign frame_msb = code;
  assign frame_lsb = code;
`endif

  // MSB-first shifts left out of the top, LSB-first shifts right out of bit 0.
  assign load_bit   = bus.mode[0] ? frame_lsb[0] : frame_msb[FRAME_W-1];
  assign load_shift = bus.mode[0] ? (frame_lsb >> 1) : (frame_msb << 1);
  assign adv_bit    = mode_q[0] ? shift_q[0] : shift_q[FRAME_W-1];
  assign adv_shift  = mode_q[0] ? (shift_q >> 1) : (shift_q << 1);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    pattern_d = 1'b0;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d   = SHIFT;
          mode_d    = bus.mode;
          shift_d   = load_shift;
          cnt_d     = '0;
          pattern_d = load_bit;
          valid_d   = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          if (mode_q[1] && bus.en) begin
            mode_d    = bus.mode;
            shift_d   = load_shift;
            cnt_d     = '0;
            pattern_d = load_bit;
            valid_d   = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else if (!mode_q[1] && !bus.en) begin
          // One-shot abort: drop the frame silently.
          state_d = IDLE;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          shift_d   = adv_shift;
          pattern_d = adv_bit;
          valid_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = bus.en ? WAIT_LOW : IDLE;
      end
      WAIT_LOW: begin
        if (!bus.en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      mode_q    <= '0;
      pattern_q <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.pattern = pattern_q;
  assign bus.valid   = valid_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
endmodule
